arm7tdmi_cp_dispatch: RTL
=========================

// Module: arm7tdmi_cp_dispatch
// PURPOSE
//  Parametrised coprocessor dispatcher between the decode stage and NUM_CP coprocessor slots (CP15 in slot 15).
//  Latches one CDP/MRC/MCR/LDC/STC request, broadcasts it to the addressed slot and runs a busy-wait handshake.
//  Returns MRC data or an undefined-instruction response on absent, refused or timed-out slots.
//  An IRQ/FIQ abort cancels the busy-wait. Replaces fixed single-cycle, CP15-only absent/busy logic.
// PARAMETERS
//  NUM_CP       16        number of slots, 1..16; cp_num >= NUM_CP is absent
//  PRESENT_MASK 16'h8000  bit n=1: slot n is populated
//  TIMEOUT      1024      max WAIT cycles before undef; 0 disables the timeout
//  DATA_W       32        data width
// PORTS
//  clk           in   1              clock
//  rst_n         in   1              async active-low reset
//  req_valid     in   1              decode presents coprocessor instruction
//  req_ready     out  1              dispatcher idle; request accepted when valid&&ready
//  req_op        in   cp_op_t        CDP/MRC/MCR/LDC/STC
//  req_num       in   4              coprocessor number
//  req_crn/crm   in   4 each         CRn, CRm
//  req_op1/op2   in   3 each         opcode fields
//  req_wdata     in   DATA_W         ARM register value (MCR)
//  abort         in   1              pending interrupt: cancel busy-wait
//  resp_valid    out  1              one-cycle completion pulse
//  resp_undef    out  1              valid with resp_valid: take undefined-instruction trap
//  resp_rdata    out  DATA_W         MRC result, valid with resp_valid
//  resp_aborted  out  1              one-cycle pulse: request cancelled, core re-executes
//  slot_req      out  NUM_CP         one-hot issue strobe, one cycle
//  slot_cancel   out  NUM_CP         one-hot cancel strobe, one cycle
//  slot_op       out  cp_op_t        latched op, held ISSUE..RESP
//  slot_crn/crm  out  4 each         latched fields, held ISSUE..RESP
//  slot_op1/op2  out  3 each         latched fields, held ISSUE..RESP
//  slot_wdata    out  DATA_W         latched write data, held ISSUE..RESP
//  slot_done     in   NUM_CP         slot finished (sampled in WAIT only)
//  slot_absent   in   NUM_CP         slot refuses instruction (sampled in WAIT only)
//  slot_rdata    in   NUM_CP*DATA_W  per-slot read data, slice n = [n*DATA_W +: DATA_W]
//  undef_count   out  16             saturating count of undef responses
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; all strobes, resp_*, counters, latched fields = 0.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; UNDEF is a RESP with resp_undef=1.
//  IDLE: req_ready=1. On accept, latch all req_* fields.
//   - num>=NUM_CP or !PRESENT_MASK[num]: next state RESP, undef=1; no slot_req.
//   - otherwise: next state ISSUE.
//  ISSUE: slot_req[num]=1 for exactly one cycle; clear wait counter; next state WAIT.
//  WAIT: counter increments each cycle. Priority, highest first:
//   1. done: capture rdata (MRC only, else 0); undef=0 -> RESP.
//   2. absent -> RESP, undef=1.
//   3. abort: slot_cancel[num]=1 next cycle, resp_aborted pulse -> IDLE; no resp_valid.
//   4. TIMEOUT!=0 and counter==TIMEOUT-1: RESP, undef=1.
//  RESP: resp_valid=1 for one cycle; undef_count++ if undef (saturates at 16'hFFFF); -> IDLE.
//  Abort in IDLE/ISSUE/RESP is ignored. slot_done/slot_absent on non-addressed slots are ignored.
//  Latency, present slot with done in first WAIT cycle: accept at cycle 0, resp_valid at cycle 3.
//  Latency, absent slot: resp_valid at cycle 1.
//  req_ready=0 from ISSUE through RESP; no request overlap.
//  Async reset mid-operation: immediate return to IDLE; no cancel strobe issued.
//  resp_rdata holds its value until the next RESP.
// STRUCTURE
//  arm7tdmi_pkg gains:
//   - cp_disp_state_t enum {CPD_IDLE, CPD_ISSUE, CPD_WAIT, CPD_RESP}
//   - CP_NUM_MAX=16
//   - cp_req_t struct {op, num, crn, crm, op1, op2, wdata}
//  Existing cp_op_t is reused.
//  One sub-module, arm7tdmi_cp_wait_timer: clear/enable counter with expiry flag at TIMEOUT-1, disabled when TIMEOUT=0.
// TESTING
//  1. MRC num=15, slot 15 done in first WAIT cycle, rdata=32'h41007000
//     -> resp_valid at cycle 3, undef=0, rdata=32'h41007000.
//  2. MCR num=14, mask 16'h8000
//     -> resp_valid at cycle 1, undef=1, slot_req never asserted, undef_count=1.
//  3. CDP num=15, busy 5 cycles, then done
//     -> resp_valid at cycle 8; slot fields stable throughout.
//  4. TIMEOUT=8, slot never done
//     -> undef response after 8 WAIT cycles; undef_count increments.
//  5. abort at WAIT cycle 2
//     -> slot_cancel[15] one-cycle pulse, resp_aborted pulse, no resp_valid, req_ready=1 next cycle.
//  6. done and abort in the same cycle -> normal response, no cancel.
//     rst_n low during WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/arm7tdmi_pkg.sv
// Shared ARM7TDMI types: coprocessor opcodes, dispatcher state and latched request.
`default_nettype none

package arm7tdmi_pkg;

  localparam int CP_NUM_MAX = 16;
  localparam int CP_DATA_W  = 32;

  typedef enum logic [2:0] {
    CP_CDP = 3'd0,
    CP_MRC = 3'd1,
    CP_MCR = 3'd2,
    CP_LDC = 3'd3,
    CP_STC = 3'd4
  } cp_op_t;

  typedef enum logic [1:0] {
    CPD_IDLE  = 2'd0,
    CPD_ISSUE = 2'd1,
    CPD_WAIT  = 2'd2,
    CPD_RESP  = 2'd3
  } cp_disp_state_t;

  typedef struct packed {
    cp_op_t               op;
    logic [3:0]           num;
    logic [3:0]           crn;
    logic [3:0]           crm;
    logic [2:0]           op1;
    logic [2:0]           op2;
    logic [CP_DATA_W-1:0] wdata;
  } cp_req_t;

endpackage

`default_nettype wire

// File: rtl/arm7tdmi_cp_wait_timer.sv
// Busy-wait cycle counter: cleared on issue, counts while waiting, flags the last allowed cycle.
`default_nettype none

module arm7tdmi_cp_wait_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [CNT_W-1:0] count;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable) begin
          count <= count + CNT_W'(1);
        end
      end

      assign expired = enable && (count == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign expired = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/arm7tdmi_cp_dispatch.sv
// Coprocessor dispatcher: latches one coprocessor instruction, issues it to the addressed
// slot, busy-waits for done/absent/abort/timeout and returns data or an undefined trap.
`default_nettype none

module arm7tdmi_cp_dispatch
  import arm7tdmi_pkg::*;
#(
  parameter int          NUM_CP       = 16,
  parameter logic [15:0] PRESENT_MASK = 16'h8000,
  parameter int          TIMEOUT      = 1024,
  parameter int          DATA_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  cp_op_t                   req_op,
  input  logic [3:0]               req_num,
  input  logic [3:0]               req_crn,
  input  logic [3:0]               req_crm,
  input  logic [2:0]               req_op1,
  input  logic [2:0]               req_op2,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic                     abort,
  output logic                     resp_valid,
  output logic                     resp_undef,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     resp_aborted,
  output logic [NUM_CP-1:0]        slot_req,
  output logic [NUM_CP-1:0]        slot_cancel,
  output cp_op_t                   slot_op,
  output logic [3:0]               slot_crn,
  output logic [3:0]               slot_crm,
  output logic [2:0]               slot_op1,
  output logic [2:0]               slot_op2,
  output logic [DATA_W-1:0]        slot_wdata,
  input  logic [NUM_CP-1:0]        slot_done,
  input  logic [NUM_CP-1:0]        slot_absent,
  input  logic [NUM_CP*DATA_W-1:0] slot_rdata,
  output logic [15:0]              undef_count
);

  cp_disp_state_t      state, next_state;
  cp_req_t             req_q;
  logic                undef_q, undef_nx;
  logic [DATA_W-1:0]   rdata_q, rdata_nx;
  logic [NUM_CP-1:0]   cancel_q;
  logic                aborted_q;

  logic                accept, req_present, load_req, abort_hit;
  logic                timer_clear, timer_en, timer_expired;
  logic                sel_done, sel_absent;
  logic [DATA_W-1:0]   sel_rdata;
  logic [NUM_CP-1:0]   num_onehot;

  assign accept = req_valid && req_ready;

  always_comb begin
    req_present = (int'(req_num) < NUM_CP) && PRESENT_MASK[req_num];
  end

  // Handshake inputs of every slot other than the latched one are ignored.
  always_comb begin
    sel_done   = 1'b0;
    sel_absent = 1'b0;
    sel_rdata  = '0;
    num_onehot = '0;
    for (int i = 0; i < NUM_CP; i++) begin
      if (req_q.num == 4'(i)) begin
        sel_done      = slot_done[i];
        sel_absent    = slot_absent[i];
        sel_rdata     = slot_rdata[i*DATA_W +: DATA_W];
        num_onehot[i] = 1'b1;
      end
    end
  end

  arm7tdmi_cp_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CPD_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    load_req    = 1'b0;
    abort_hit   = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    undef_nx    = undef_q;
    rdata_nx    = rdata_q;
    case (state)
      CPD_IDLE: begin
        if (accept) begin
          load_req = 1'b1;
          if (req_present) begin
            next_state = CPD_ISSUE;
          end else begin
            next_state = CPD_RESP;
            undef_nx   = 1'b1;
            rdata_nx   = '0;
          end
        end
      end
      CPD_ISSUE: begin
        timer_clear = 1'b1;
        next_state  = CPD_WAIT;
      end
      CPD_WAIT: begin
        timer_en = 1'b1;
        if (sel_done) begin
          next_state = CPD_RESP;
          undef_nx   = 1'b0;
          rdata_nx   = (req_q.op == CP_MRC) ? sel_rdata : '0;
        end else if (sel_absent) begin
          next_state = CPD_RESP;
          undef_nx   = 1'b1;
          rdata_nx   = '0;
        end else if (abort) begin
          next_state = CPD_IDLE;
          abort_hit  = 1'b1;
        end else if (timer_expired) begin
          next_state = CPD_RESP;
          undef_nx   = 1'b1;
          rdata_nx   = '0;
        end
      end
      CPD_RESP: begin
        next_state = CPD_IDLE;
      end
      default: begin
        next_state = CPD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      undef_q     <= 1'b0;
      rdata_q     <= '0;
      cancel_q    <= '0;
      aborted_q   <= 1'b0;
      undef_count <= '0;
    end else begin
      if (load_req) begin
        req_q.op    <= req_op;
        req_q.num   <= req_num;
        req_q.crn   <= req_crn;
        req_q.crm   <= req_crm;
        req_q.op1   <= req_op1;
        req_q.op2   <= req_op2;
        req_q.wdata <= CP_DATA_W'(req_wdata);
      end
      undef_q   <= undef_nx;
      rdata_q   <= rdata_nx;
      cancel_q  <= abort_hit ? num_onehot : '0;
      aborted_q <= abort_hit;
      if (state == CPD_RESP && undef_q && undef_count != 16'hFFFF) begin
        undef_count <= undef_count + 16'd1;
      end
    end
  end

  assign req_ready    = (state == CPD_IDLE);
  assign resp_valid   = (state == CPD_RESP);
  assign resp_undef   = (state == CPD_RESP) && undef_q;
  assign resp_rdata   = rdata_q;
  assign resp_aborted = aborted_q;
  assign slot_req     = (state == CPD_ISSUE) ? num_onehot : '0;
  assign slot_cancel  = cancel_q;
  assign slot_op      = req_q.op;
  assign slot_crn     = req_q.crn;
  assign slot_crm     = req_q.crm;
  assign slot_op1     = req_q.op1;
  assign slot_op2     = req_q.op2;
  assign slot_wdata   = DATA_W'(req_q.wdata);

endmodule

`default_nettype wire
